alu_rr_scheduler: RTL and testbench

- Shares one multi-cycle ALU (add/sub/mul) between 4 requesters.
- Arbitration is round-robin. Winning operands are latched and the operation is sequenced through a small FSM. One result is returned per grant, tagged with the requester id.
- Sits between client blocks and the shared arithmetic datapath; the operand select is the 4-to-1 mux function.

---
 rtl/alu_sched_pkg.sv | 17 +
 rtl/rr_arbiter4.sv | 34 +++
 rtl/alu_rr_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared definitions for the round-robin ALU scheduler.
//   Opcode encodings used on the per-requester op fields.
//   FSM state encoding for the scheduler sequencer.
package alu_sched_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_INV = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter.
// Ports:
//   req        in  4  request vector
//   ptr        in  2  index of the most recent winner; search starts at ptr+1
//   any        out 1  at least one request present
//   gnt_idx    out 2  index of the winning requester (0 when any=0)
//   gnt_onehot out 4  one-hot form of gnt_idx (0 when any=0)
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] gnt_idx,
  output logic [3:0] gnt_onehot
);

  logic [1:0] idx;

  // Walk ptr+1, ptr+2, ptr+3, ptr+4 (== ptr); the 2-bit add gives the 3->0 wrap.
  always_comb begin
    any     = 1'b0;
    gnt_idx = 2'd0;
    idx     = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign gnt_onehot = any ? (4'b0001 << gnt_idx) : 4'b0000;

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one multi-cycle add/sub/mul ALU between four requesters using
// round-robin arbitration. The winner's opcode and operands are latched at
// grant time, so requesters may change or drop their inputs afterwards.
// Ports:
//   clk      in  1        system clock, rising edge
//   rst_n    in  1        synchronous active-low reset
//   req      in  4        per-requester request
//   op       in  8        per-requester opcode, [2i+1:2i] for requester i
//   a_bus    in  4*WIDTH  per-requester operand A, [WIDTH*i +: WIDTH]
//   b_bus    in  4*WIDTH  per-requester operand B, same slicing
//   gnt      out 4        one-hot grant pulse
//   busy     out 1        scheduler not idle
//   done     out 1        result-valid pulse
//   done_id  out 2        requester owning result
//   result   out 2*WIDTH  ALU result
//   err      out 1        invalid opcode, qualified by done
//
// state  | meaning
// S_IDLE | waiting for any request; arbitrates and latches the winner
// S_EXEC | counting down execution cycles; result registered when cnt==0
// S_RESP | response cycle; done/done_id are registered out of this state
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           req,
  input  logic [7:0]           op,
  input  logic [4*WIDTH-1:0]   a_bus,
  input  logic [4*WIDTH-1:0]   b_bus,
  output logic [3:0]           gnt,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           done_id,
  output logic [2*WIDTH-1:0]   result,
  output logic                 err
);

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  state_t             state_q, state_d;
  logic [1:0]         rr_ptr_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [1:0]         id_q;
  logic [3:0]         cnt_q;

  logic               arb_any;
  logic [1:0]         arb_idx;
  logic [3:0]         arb_onehot;

  logic [1:0]         op_sel;
  logic [WIDTH-1:0]   a_sel, b_sel;

  logic               pick;
  logic               finish;
  logic [3:0]         cnt_load;

  logic [2*WIDTH-1:0] a_ext, b_ext;
  logic [2*WIDTH-1:0] alu_res;
  logic               alu_err;

  rr_arbiter4 u_arb (
    .req        (req),
    .ptr        (rr_ptr_q),
    .any        (arb_any),
    .gnt_idx    (arb_idx),
    .gnt_onehot (arb_onehot)
  );

  // Operand select: 4-to-1 mux on the arbitration winner.
  always_comb begin
    op_sel = op[1:0];
    a_sel  = a_bus[0 +: WIDTH];
    b_sel  = b_bus[0 +: WIDTH];
    case (arb_idx)
      2'd0: begin
        op_sel = op[1:0];
        a_sel  = a_bus[0 +: WIDTH];
        b_sel  = b_bus[0 +: WIDTH];
      end
      2'd1: begin
        op_sel = op[3:2];
        a_sel  = a_bus[WIDTH +: WIDTH];
        b_sel  = b_bus[WIDTH +: WIDTH];
      end
      2'd2: begin
        op_sel = op[5:4];
        a_sel  = a_bus[2*WIDTH +: WIDTH];
        b_sel  = b_bus[2*WIDTH +: WIDTH];
      end
      default: begin
        op_sel = op[7:6];
        a_sel  = a_bus[3*WIDTH +: WIDTH];
        b_sel  = b_bus[3*WIDTH +: WIDTH];
      end
    endcase
  end

  assign cnt_load = (op_sel == OP_MUL) ? MUL_LOAD : 4'd0;

  // Datapath on the latched operands, zero-extended to the result width.
  assign a_ext = {{WIDTH{1'b0}}, a_q};
  assign b_ext = {{WIDTH{1'b0}}, b_q};

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (op_q)
      OP_ADD:  alu_res = a_ext + b_ext;
      OP_SUB:  alu_res = a_ext - b_ext;
      OP_MUL:  alu_res = a_ext * b_ext;
      default: begin
        alu_res = '0;
        alu_err = 1'b1;
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    pick    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          pick    = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'd0) begin
          finish  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= 2'd3;
      op_q     <= 2'd0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 2'd0;
      cnt_q    <= 4'd0;
      gnt      <= 4'd0;
      done     <= 1'b0;
      done_id  <= 2'd0;
      result   <= '0;
      err      <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt     <= pick ? arb_onehot : 4'd0;
      // done is registered out of RESP so it appears in the first IDLE cycle,
      // which keeps it disjoint from the next grant.
      done    <= (state_q == S_RESP);

      if (pick) begin
        op_q     <= op_sel;
        a_q      <= a_sel;
        b_q      <= b_sel;
        id_q     <= arb_idx;
        rr_ptr_q <= arb_idx;
        cnt_q    <= cnt_load;
      end else if (state_q == S_EXEC && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end

      if (finish) begin
        result <= alu_res;
        err    <= alu_err;
      end

      if (state_q == S_RESP) begin
        done_id <= id_q;
      end
    end
  end

  assign busy = (state_q != S_IDLE);

  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_gnt_done   : assert property (@(posedge clk) disable iff (!rst_n) !(done && (gnt != 4'd0)));

endmodule

// File: tb/tb_alu_rr_scheduler.sv
module tb_alu_rr_scheduler;
  localparam int WIDTH      = 8;
  localparam int MUL_CYCLES = 4;
  localparam int RES_MOD    = 1 << (2 * WIDTH);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [3:0]           req = 4'd0;
  logic [7:0]           op = 8'd0;
  logic [4*WIDTH-1:0]   a_bus = '0;
  logic [4*WIDTH-1:0]   b_bus = '0;
  logic [3:0]           gnt;
  logic                 busy;
  logic                 done;
  logic [1:0]           done_id;
  logic [2*WIDTH-1:0]   result;
  logic                 err;

  int checks = 0;
  int passes = 0;
  int last_win = 3;
  bit outstanding = 1'b0;

  alu_rr_scheduler #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .op      (op),
    .a_bus   (a_bus),
    .b_bus   (b_bus),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .result  (result),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Round-robin reference: first requester after the last winner, wrapping.
  function automatic int ref_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic int ref_res(input int o, input int a, input int b);
    case (o)
      0:       return a + b;
      1:       return (a - b + RES_MOD) % RES_MOD;
      2:       return a * b;
      default: return 0;
    endcase
  endfunction

  task automatic set_lane(input int i, input int o, input int a, input int b);
    op[2*i +: 2]          = 2'(o);
    a_bus[WIDTH*i +: WIDTH] = WIDTH'(a);
    b_bus[WIDTH*i +: WIDTH] = WIDTH'(b);
  endtask

  task automatic randomize_lanes();
    for (int i = 0; i < 4; i++)
      set_lane(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
  endtask

  // Protocol-level invariants, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) outstanding = 1'b0;
    else begin
      if (gnt != 4'd0) begin
        check("gnt_onehot", 32'($onehot(gnt)), 32'd1);
        check("gnt_before_done", 32'(outstanding), 32'd0);
        outstanding = 1'b1;
      end
      if (done) begin
        check("done_gnt_excl", 32'(gnt), 32'd0);
        outstanding = 1'b0;
      end
    end
  end

  // Runs one transaction. Inputs are already set at a negedge with the DUT idle.
  task automatic do_txn(input bit disturb, input bit drop, output int win);
    int w, eo, ea, eb, n, lat, exp_lat;
    w  = ref_pick(req, last_win);
    win = w;
    eo = int'(op[2*w +: 2]);
    ea = int'(a_bus[WIDTH*w +: WIDTH]);
    eb = int'(b_bus[WIDTH*w +: WIDTH]);
    n = 0;
    while (gnt == 4'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (gnt == 4'd0) begin
      check("gnt_timeout", 32'd0, 32'd1);
      return;
    end
    check("gnt_delay", 32'(n), 32'd1);
    check("gnt_winner", 32'(gnt), 32'(4'b0001 << w));
    check("busy_at_gnt", 32'(busy), 32'd1);
    last_win = w;
    if (disturb) randomize_lanes();
    if (drop) req[w] = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      check("done_timeout", 32'd0, 32'd1);
      return;
    end
    exp_lat = (eo == 2) ? MUL_CYCLES + 1 : 2;
    check("done_latency", 32'(lat), 32'(exp_lat));
    check("done_id", 32'(done_id), 32'(w));
    check("result", 32'(result), 32'(ref_res(eo, ea, eb)));
    check("err", 32'(err), (eo == 3) ? 32'd1 : 32'd0);
    check("busy_at_done", 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    // Reset hold with all requests asserted.
    rst_n = 1'b0;
    req   = 4'hF;
    randomize_lanes();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_result", 32'(result), 32'd0);
    end

    // Single ADD on requester 0.
    req = 4'b0001;
    set_lane(0, 0, 200, 100);
    rst_n = 1'b1;
    do_txn(1'b0, 1'b0, w);
    check("add_300", 32'(result), 32'd300);

    // Multiply latency on requester 2.
    req = 4'b0100;
    set_lane(2, 2, 255, 255);
    do_txn(1'b0, 1'b0, w);
    check("mul_fe01", 32'(result), 32'hFE01);

    // SUB wrap on requester 0, invalid op on requester 1.
    req = 4'b0001;
    set_lane(0, 1, 3, 5);
    do_txn(1'b0, 1'b0, w);
    check("sub_wrap", 32'(result), 32'hFFFE);
    req = 4'b0010;
    set_lane(1, 3, 17, 42);
    do_txn(1'b0, 1'b0, w);
    check("inv_err", 32'(err), 32'd1);
    check("inv_id", 32'(done_id), 32'd1);

    // MUL on requester 3 with operands scrambled and req dropped mid-operation.
    req = 4'b1000;
    set_lane(3, 2, 123, 45);
    do_txn(1'b1, 1'b1, w);
    check("disturb_mul", 32'(result), 32'd5535);

    // Fairness: all four requesting continuously.
    req = 4'hF;
    for (int i = 0; i < 4; i++) set_lane(i, 0, 10 * i, i);
    for (int k = 0; k < 8; k++) begin
      do_txn(1'b0, 1'b0, w);
      check("rr_order", 32'(w), 32'(k % 4));
    end

    // Randomized traffic.
    for (int k = 0; k < 60; k++) begin
      req = 4'($urandom_range(1, 15));
      randomize_lanes();
      do_txn(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), w);
    end

    // Reset during EXEC of a multiply aborts it.
    req = 4'b0100;
    set_lane(2, 2, 9, 9);
    begin
      int n;
      n = 0;
      while (gnt == 4'd0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("abort_gnt", 32'(gnt), 32'b0100);
    end
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_rst_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    last_win = 3;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("abort_done", 32'(done), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
      check("abort_gnt_quiet", 32'(gnt), 32'd0);
    end

    // After reset the pointer restarts so requester 0 wins first.
    req = 4'hF;
    randomize_lanes();
    do_txn(1'b0, 1'b0, w);
    check("post_rst_rr", 32'(w), 32'd0);

    req = 4'd0;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
